// File: rtl/adder_measure_seq.sv
// adder_measure_seq: sequences repeated runs of an instrumented adder and collects sum/delay statistics
// Ports:
//   wb_clk_i, wb_rst_n        clock, synchronous active-low reset
//   start, a_in, b_in         sequence request and operands (sampled when idle)
//   num_runs                  number of runs, 0 behaves as 1
//   adder_a/b, adder_run      registered operands and run enable towards the adder
//   adder_done/sum/count      result handshake, sum and delay count from the adder
//   busy, done                sequence in progress, one-cycle end-of-sequence pulse
//   last_sum, min/max_count   latest sum and delay extremes over completed runs
//   err_count, timeout_flag   saturating error count, sticky timeout indicator
module adder_measure_seq #(
   parameter int WIDTH   = 32,
   parameter int RUNS_W  = 8,
   parameter int TIMEOUT = 1023,
   parameter int SETTLE  = 4
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              start,
   input  logic [WIDTH-1:0]  a_in,
   input  logic [WIDTH-1:0]  b_in,
   input  logic [RUNS_W-1:0] num_runs,
   output logic [WIDTH-1:0]  adder_a,
   output logic [WIDTH-1:0]  adder_b,
   output logic              adder_run,
   input  logic              adder_done,
   input  logic [WIDTH-1:0]  adder_sum,
   input  logic [WIDTH-1:0]  adder_count,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  last_sum,
   output logic [WIDTH-1:0]  min_count,
   output logic [WIDTH-1:0]  max_count,
   output logic [RUNS_W-1:0] err_count,
   output logic              timeout_flag
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(SETTLE + 1);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_SETTLE  = 3'd4;
   localparam logic [2:0] S_FINISH  = 3'd5;
   logic [2:0]        state;
   logic [RUNS_W-1:0] remaining;
   logic [TW-1:0]     tcnt;
   logic [SW-1:0]     scnt;
   logic [WIDTH-1:0]  ref_sum;
   logic [RUNS_W-1:0] err_inc;
   assign ref_sum   = adder_a + adder_b;
   assign err_inc   = (err_count == '1) ? err_count : err_count + RUNS_W'(1);
   assign adder_run = state == S_RUN;
   assign done      = state == S_FINISH;
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         state        <= S_IDLE;
         adder_a      <= '0;
         adder_b      <= '0;
         remaining    <= '0;
         tcnt         <= '0;
         scnt         <= '0;
         busy         <= 1'b0;
         last_sum     <= '0;
         min_count    <= '1;
         max_count    <= '0;
         err_count    <= '0;
         timeout_flag <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               adder_a      <= a_in;
               adder_b      <= b_in;
               remaining    <= (num_runs == '0) ? RUNS_W'(1) : num_runs;
               err_count    <= '0;
               timeout_flag <= 1'b0;
               min_count    <= '1;
               max_count    <= '0;
               busy         <= 1'b1;
               state        <= S_LOAD;
            end
            S_LOAD: begin
               tcnt  <= '0;
               state <= S_RUN;
            end
            // done takes priority over a timeout in the same cycle
            S_RUN: if (adder_done) state <= S_CAPTURE;
            else if (tcnt == TW'(TIMEOUT - 1)) begin
               err_count    <= err_inc;
               timeout_flag <= 1'b1;
               scnt         <= '0;
               state        <= S_SETTLE;
            end else tcnt <= tcnt + TW'(1);
            S_CAPTURE: begin
               last_sum  <= adder_sum;
               err_count <= (adder_sum != ref_sum) ? err_inc : err_count;
               min_count <= (adder_count < min_count) ? adder_count : min_count;
               max_count <= (adder_count > max_count) ? adder_count : max_count;
               scnt      <= '0;
               state     <= S_SETTLE;
            end
            S_SETTLE: if (scnt == SW'(SETTLE - 1)) begin
               remaining <= remaining - RUNS_W'(1);
               state     <= (remaining == RUNS_W'(1)) ? S_FINISH : S_LOAD;
            end else scnt <= scnt + SW'(1);
            S_FINISH: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adder_measure_seq.sv
// tb_adder_measure_seq: directed table-driven bench for adder_measure_seq with a behavioural adder model
module tb_adder_measure_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a_in = '0, b_in = '0;
   logic [7:0]  num_runs = '0;
   logic [31:0] adder_a, adder_b, adder_sum, adder_count;
   logic        adder_run, adder_done, busy, done, timeout_flag;
   logic [31:0] last_sum, min_count, max_count;
   logic [7:0]  err_count;
   always #5 clk = ~clk;
   adder_measure_seq #(.WIDTH(32), .RUNS_W(8), .TIMEOUT(16), .SETTLE(4)) dut (
      .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
      .num_runs(num_runs), .adder_a(adder_a), .adder_b(adder_b), .adder_run(adder_run),
      .adder_done(adder_done), .adder_sum(adder_sum), .adder_count(adder_count),
      .busy(busy), .done(done), .last_sum(last_sum), .min_count(min_count),
      .max_count(max_count), .err_count(err_count), .timeout_flag(timeout_flag)
   );
   int             mt = 0;
   logic [31:0]    md = '0;
   logic [3:0][31:0] mc = '0;
   int rc = 0, cur_len = 0, gap = 0, nruns_seen = 0, done_cnt = 0, min_gap = 1000, base = 0, idx;
   int lens [64];
   always_comb begin
      idx = nruns_seen - base;
      if (idx > 3) idx = 3;
      if (idx < 0) idx = 0;
      adder_done  = adder_run && mt != 0 && rc == mt - 1;
      adder_sum   = adder_a + adder_b + md;
      adder_count = mc[idx];
   end
   always @(posedge clk) begin
      rc <= adder_run ? rc + 1 : 0;
      done_cnt <= done_cnt + int'(done);
      if (adder_run) begin
         cur_len <= cur_len + 1;
         if (gap != 0 && nruns_seen > base && gap < min_gap) min_gap <= gap;
         gap <= 0;
      end else begin
         gap <= gap + 1;
         if (cur_len != 0) begin
            lens[nruns_seen % 64] <= cur_len;
            nruns_seen <= nruns_seen + 1;
            cur_len <= 0;
         end
      end
   end
   int cmps = 0, fails = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      cmps++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask
   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", done, 1);
   endtask
   typedef struct {
      logic [31:0] a, b;
      int n, t;
      logic [31:0] d;
      logic [3:0][31:0] c;
      logic [31:0] e_last, e_min, e_max;
      int e_err, e_tf, e_runs;
   } vec_t;
   function automatic vec_t mk(input logic [31:0] a, b, input int n, t, input logic [31:0] d, c0, c1, c2, c3,
                               l, mn, mx, input int err, tf, runs);
      vec_t v;
      v.a = a; v.b = b; v.n = n; v.t = t; v.d = d;
      v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
      v.e_last = l; v.e_min = mn; v.e_max = mx; v.e_err = err; v.e_tf = tf; v.e_runs = runs;
      return v;
   endfunction
   task automatic run_vec(input vec_t v, input int vi);
      int db;
      base = nruns_seen;
      db = done_cnt;
      mt = v.t; md = v.d; mc = v.c;
      @(negedge clk);
      a_in = v.a; b_in = v.b; num_runs = 8'(v.n); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d_busy", vi), busy, 1);
      wait_done(3000);
      chk($sformatf("v%0d_last_sum", vi), last_sum, v.e_last);
      chk($sformatf("v%0d_min", vi), min_count, v.e_min);
      chk($sformatf("v%0d_max", vi), max_count, v.e_max);
      chk($sformatf("v%0d_err", vi), err_count, 64'(v.e_err));
      chk($sformatf("v%0d_tflag", vi), timeout_flag, 64'(v.e_tf));
      chk($sformatf("v%0d_runs", vi), 64'(nruns_seen - base), 64'(v.e_runs));
      for (int i = 0; i < v.e_runs; i++)
         chk($sformatf("v%0d_runlen%0d", vi, i), 64'(lens[(base + i) % 64]), 64'(v.t == 0 ? 16 : v.t));
      @(negedge clk);
      chk($sformatf("v%0d_busy_drop", vi), busy, 0);
      chk($sformatf("v%0d_done_once", vi), 64'(done_cnt - db), 1);
   endtask
   vec_t vt [7];
   initial begin
      int k, db;
      vt[0] = mk(32'd5, 32'd7, 1, 3, 0, 40, 0, 0, 0, 32'd12, 32'd40, 32'd40, 0, 0, 1);
      vt[1] = mk(32'hFFFF_FFFF, 32'd1, 1, 2, 0, 9, 0, 0, 0, 32'd0, 32'd9, 32'd9, 0, 0, 1);
      vt[2] = mk(32'hFFFF_FFFF, 32'd1, 1, 2, 1, 9, 0, 0, 0, 32'd1, 32'd9, 32'd9, 1, 0, 1);
      vt[3] = mk(32'd8, 32'd9, 3, 0, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'd0, 3, 1, 3);
      vt[4] = mk(32'd100, 32'd23, 4, 5, 0, 30, 12, 55, 20, 32'd123, 32'd12, 32'd55, 0, 0, 4);
      vt[5] = mk(32'd3, 32'd4, 0, 16, 0, 7, 0, 0, 0, 32'd7, 32'd7, 32'd7, 0, 0, 1);
      vt[6] = mk(32'd10, 32'd20, 2, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 32'd30, 32'd0, 32'hFFFF_FFFF, 0, 0, 2);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_run", adder_run, 0);
      chk("rst_done", done, 0);
      chk("rst_min", min_count, 32'hFFFF_FFFF);
      chk("rst_max", max_count, 0);
      chk("rst_err", err_count, 0);
      chk("rst_last", last_sum, 0);
      chk("rst_adder_a", adder_a, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) run_vec(vt[i], i);
      chk("min_gap_ge_settle1", 64'(min_gap >= 5), 1);
      // start while busy is ignored; start coinciding with the done pulse is ignored
      mt = 8; md = 0; mc = '0;
      @(negedge clk);
      a_in = 32'd1; b_in = 32'd2; num_runs = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      a_in = 32'd99; b_in = 32'd99; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("busy_start_a", adder_a, 32'd1);
      chk("busy_start_b", adder_b, 32'd2);
      wait_done(3000);
      chk("busy_start_last", last_sum, 32'd3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("finish_start_busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("finish_start_run", adder_run, 0);
      chk("finish_start_a", adder_a, 32'd1);
      // reset during the second run of a timing-out sequence
      mt = 0;
      @(negedge clk);
      a_in = 32'd5; b_in = 32'd5; num_runs = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(timeout_flag && adder_run) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("mid_second_run", 64'(timeout_flag && adder_run), 1);
      chk("mid_err_before", err_count, 1);
      @(negedge clk);
      rst_n = 1'b0;
      db = done_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_run", adder_run, 0);
      chk("mid_rst_err", err_count, 0);
      chk("mid_rst_min", min_count, 32'hFFFF_FFFF);
      chk("mid_rst_tflag", timeout_flag, 0);
      repeat (40) @(negedge clk);
      chk("mid_rst_no_done", 64'(done_cnt - db), 0);
      chk("mid_rst_idle", adder_run, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
      $finish;
   end
endmodule

// File: doc/adder_measure_seq.md
Name: adder_measure_seq

Overview:
Measurement sequencer that sits directly upstream of the wrapped instrumented Kogge-Stone adder and also consumes its results. It latches operands from the LA interface and runs the adder for a programmed number of measurements. For each run it captures the adder's sum and delay count, checks the sum against a reference a+b, and tracks min/max delay and an error count. The LA readback taps its results.

Parameters:
WIDTH, 32, operand/sum/count width
RUNS_W, 8, width of run-count and error-count registers
TIMEOUT, 1023, max cycles in RUN before a run is aborted (≥1)
SETTLE, 4, idle cycles with adder_run low between runs (≥1)

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge
wb_rst_n  in  1  synchronous reset, active low
start  in  1  single-cycle request; ignored while busy
a_in  in  WIDTH  operand A, sampled on accepted start
b_in  in  WIDTH  operand B, sampled on accepted start
num_runs  in  RUNS_W  runs to perform; 0 treated as 1
adder_a  out  WIDTH  operand A to adder (registered)
adder_b  out  WIDTH  operand B to adder (registered)
adder_run  out  1  level: adder measurement enabled
adder_done  in  1  adder reports result valid (level or pulse)
adder_sum  in  WIDTH  adder sum output
adder_count  in  WIDTH  adder delay counter value
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of sequence
last_sum  out  WIDTH  sum captured in the most recent run
min_count  out  WIDTH  minimum adder_count over non-timeout runs
max_count  out  WIDTH  maximum adder_count over non-timeout runs
err_count  out  RUNS_W  runs with sum mismatch or timeout (saturating)
timeout_flag  out  1  sticky: at least one run timed out this sequence

Behaviour:
- Reset (wb_rst_n=0 at clock edge) clears all outputs and state to 0, except min_count, which resets to all-ones. FSM goes to IDLE. Reset mid-sequence aborts immediately. adder_run is low the cycle after the reset edge.
- FSM states:
  - IDLE: busy=0. start=1 latches a_in/b_in into adder_a/adder_b and loads remaining = max(num_runs,1). It clears err_count and timeout_flag, sets min_count=all-ones and max_count=0, and moves to LOAD.
  - LOAD: one cycle. Operands are stable, adder_run=0. Next state is RUN.
  - RUN: adder_run=1 and a timeout counter increments each cycle.
    - adder_done=1: go to CAPTURE.
    - Timeout counter reaches TIMEOUT with done low: increment err_count, set timeout_flag, go to SETTLE. last_sum and min/max are not updated.
    - done and timeout in the same cycle: done wins.
  - CAPTURE: one cycle. adder_run=0.
    - last_sum <= adder_sum.
    - adder_sum != (adder_a+adder_b) mod 2^WIDTH: err_count+1.
    - min_count <= min(min_count, adder_count) and max_count <= max(max_count, adder_count), compared unsigned.
    - Next state is SETTLE.
  - SETTLE: adder_run=0 for SETTLE cycles. Then remaining-1; if the result is 0, go to FINISH, else go to LOAD.
  - FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- busy is registered: it is 1 the cycle after an accepted start and 0 the cycle after FINISH.
- err_count saturates at 2^RUNS_W-1.
- adder_done is sampled only in RUN. A done held high across runs is not counted twice, because LOAD and SETTLE always intervene.
- start while busy is ignored; operands do not change mid-sequence.
- start in the same cycle as FINISH is ignored. A new sequence needs start while IDLE.
- Per-run latency is 1 (LOAD) + t_done + 1 (CAPTURE) + SETTLE cycles.

Test Plan:
- Single run: reset, then start with a=5, b=7, num_runs=1. Model asserts done 3 cycles into RUN with sum=12, count=40 -> last_sum=12, min=max=40, err_count=0, done pulses once, busy drops the next cycle.
- Wrap-around: a=0xFFFFFFFF, b=1, model sum=0 -> err_count=0. Same operands with model sum=0x1 -> err_count=1.
- Timeout: adder_done never asserted, TIMEOUT=16, num_runs=3 -> adder_run high exactly 16 cycles per run, err_count=3, timeout_flag=1, min_count=0xFFFFFFFF, max_count=0.
- Multi-run statistics: num_runs=4 with counts 30, 12, 55, 20 -> min=12, max=55, last_sum correct, adder_run low for ≥SETTLE+1 cycles between runs.
- num_runs=0 -> exactly one run. start pulsed during busy -> ignored, operands unchanged.
- Reset mid-RUN: wb_rst_n low for 1 cycle -> busy=0, adder_run=0, err_count=0, min_count=all-ones next cycle, no done pulse.
